mem_arbiter: RTL and testbench

Single-port memory arbiter that shares the core's one data memory between the instruction-fetch path and the load/store path. It sits between the fetch/execute logic and the `memory` instance. It grants one requester per access and sequences the fixed-latency read return back to the owner. Data accesses have priority, and an optional starvation guard bounds fetch wait time.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the arbiter and the single-port data memory.
// master = requester/memory side, slave = arbiter side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_rw, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data port has priority over fetch, fixed-latency read return.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              gnt_if, gnt_d;
    logic              rd_return;
    logic              starve_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = (starve_cnt_q == STARVE_W'(STARVE_MAX));

    // Counts consecutive arbitrations fetch lost to the data port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt_if) begin
            starve_cnt_d = '0;
        end else if (gnt_d && bus.if_req && !starve_force) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end
`else
    logic unused_starve_max;

    assign starve_force      = 1'b0;
    assign unused_starve_max = ^32'(STARVE_MAX);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Next-state: any read grant parks the FSM in WAIT until its data returns.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_if || (gnt_d && !bus.d_we)) begin
                    state_d   = ST_WAIT;
                    owner_d   = gnt_d ? OWN_D : OWN_IF;
                    lat_cnt_d = LAT_W'(1);
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_W'(MEM_LAT)) begin
                    state_d   = ST_IDLE;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
        endcase
    end

    // Outputs: grants and memory command are combinational from the requests.
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.if_req && (starve_force || !bus.d_req)) begin
                gnt_if = 1'b1;
            end else if (bus.d_req) begin
                gnt_d = 1'b1;
            end
        end

        bus.if_gnt    = gnt_if;
        bus.d_gnt     = gnt_d;
        bus.mem_en    = gnt_if | gnt_d;
        bus.mem_rw    = gnt_d & bus.d_we;
        bus.mem_addr  = ADDR_W'(0);
        bus.mem_wdata = DATA_W'(0);
        if (gnt_d) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (gnt_if) begin
            bus.mem_addr  = bus.if_addr;
        end

        rd_return     = (state_q == ST_WAIT) && (lat_cnt_q == LAT_W'(MEM_LAT));
        bus.if_rvalid = rd_return && (owner_q == OWN_IF);
        bus.d_rvalid  = rd_return && (owner_q == OWN_D);
        bus.if_rdata  = bus.mem_rdata;
        bus.d_rdata   = bus.mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances at MEM_LAT = 1, 2 and 3 sharing clock and reset.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clk(clk), .reset(reset), .bus(b1));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_lat2 (
        .clk(clk), .reset(reset), .bus(b2));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
        .clk(clk), .reset(reset), .bus(b3));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b0;
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
        b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
        b1.mem_rdata = 32'hA5A5_0100;
        b2.mem_rdata = 32'h2222_0500;
        b3.mem_rdata = 32'h3333_0600;
        #1;
        check_eq("rst_if_gnt",    32'(b1.if_gnt),    32'd0);
        check_eq("rst_d_gnt",     32'(b1.d_gnt),     32'd0);
        check_eq("rst_if_rvalid", 32'(b1.if_rvalid), 32'd0);
        check_eq("rst_d_rvalid",  32'(b1.d_rvalid),  32'd0);
        check_eq("rst_mem_en",    32'(b1.mem_en),    32'd0);
        check_eq("rst_mem_rw",    32'(b1.mem_rw),    32'd0);
        check_eq("rst_mem_addr",  b1.mem_addr,       32'd0);
        check_eq("rst_mem_wdata", b1.mem_wdata,      32'd0);
        repeat (2) tick();
        reset = 1'b1;

        // Single fetch read, MEM_LAT=1, with a second fetch queued behind it.
        tick(); b1.if_req = 1; b1.if_addr = 32'h100; settle();
        check_eq("f_gnt",      32'(b1.if_gnt), 32'd1);
        check_eq("f_mem_en",   32'(b1.mem_en), 32'd1);
        check_eq("f_mem_rw",   32'(b1.mem_rw), 32'd0);
        check_eq("f_mem_addr", b1.mem_addr,    32'h100);
        tick(); b1.if_addr = 32'h104; settle();
        check_eq("f_rvalid",   32'(b1.if_rvalid), 32'd1);
        check_eq("f_rdata",    b1.if_rdata,       32'hA5A5_0100);
        check_eq("f_wait_gnt", 32'(b1.if_gnt),    32'd0);
        check_eq("f_wait_en",  32'(b1.mem_en),    32'd0);
        tick(); settle();
        check_eq("f2_gnt",      32'(b1.if_gnt), 32'd1);
        check_eq("f2_mem_addr", b1.mem_addr,    32'h104);
        tick(); b1.if_req = 0; settle();
        check_eq("f2_rvalid", 32'(b1.if_rvalid), 32'd1);

        // Conflict: load wins, fetch follows in the first IDLE cycle.
        tick(); b1.if_req = 1; b1.if_addr = 32'h300; b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h200; settle();
        check_eq("c_d_gnt",   32'(b1.d_gnt),  32'd1);
        check_eq("c_if_gnt",  32'(b1.if_gnt), 32'd0);
        check_eq("c_addr",    b1.mem_addr,    32'h200);
        check_eq("c_rw",      32'(b1.mem_rw), 32'd0);
        tick(); b1.d_req = 0; settle();
        check_eq("c_d_rvalid",  32'(b1.d_rvalid),  32'd1);
        check_eq("c_d_rdata",   b1.d_rdata,        32'hA5A5_0100);
        check_eq("c_if_rvalid", 32'(b1.if_rvalid), 32'd0);
        check_eq("c_if_wait",   32'(b1.if_gnt),    32'd0);
        tick(); settle();
        check_eq("c_if_gnt2",  32'(b1.if_gnt), 32'd1);
        check_eq("c_if_addr",  b1.mem_addr,    32'h300);
        tick(); b1.if_req = 0; settle();
        check_eq("c_if_rvalid2", 32'(b1.if_rvalid), 32'd1);
        check_eq("c_d_rvalid2",  32'(b1.d_rvalid),  32'd0);

        // Back-to-back stores.
        for (int i = 0; i < 3; i++) begin
            tick(); b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h10 + 32'(4 * i);
            b1.d_wdata = 32'hD000_0000 + 32'(i); settle();
            check_eq("st_gnt",    32'(b1.d_gnt),    32'd1);
            check_eq("st_en",     32'(b1.mem_en),   32'd1);
            check_eq("st_rw",     32'(b1.mem_rw),   32'd1);
            check_eq("st_addr",   b1.mem_addr,      32'h10 + 32'(4 * i));
            check_eq("st_wdata",  b1.mem_wdata,     32'hD000_0000 + 32'(i));
            check_eq("st_rvalid", 32'(b1.d_rvalid), 32'd0);
        end
        tick(); b1.d_req = 0; settle();
        check_eq("st_idle_en",  32'(b1.mem_en),   32'd0);
        check_eq("st_idle_rv",  32'(b1.d_rvalid), 32'd0);

        // Starvation: continuous stores with a pending fetch.
        for (int i = 0; i < 6; i++) begin
            tick(); b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h20; b1.d_wdata = 32'h5;
            b1.if_req = GUARD_EN ? (i <= 4) : 1'b1; b1.if_addr = 32'h400; settle();
            check_eq("sv_if_gnt", 32'(b1.if_gnt), 32'(GUARD_EN && i == 4));
            check_eq("sv_d_gnt",  32'(b1.d_gnt),  32'(GUARD_EN ? (i < 4) : 1'b1));
        end
        tick(); b1.d_req = 0; b1.if_req = 0; settle();

        // Reset mid-read on the MEM_LAT=2 instance.
        tick(); b2.if_req = 1; b2.if_addr = 32'h500; settle();
        check_eq("rr_gnt", 32'(b2.if_gnt), 32'd1);
        tick(); b2.if_req = 0; settle();
        check_eq("rr_rv_early", 32'(b2.if_rvalid), 32'd0);
        reset = 1'b0; #1;
        check_eq("rr_rv_rst", 32'(b2.if_rvalid), 32'd0);
        reset = 1'b1;
        tick(); b2.if_req = 1; b2.if_addr = 32'h504; settle();
        check_eq("rr_no_rv",   32'(b2.if_rvalid), 32'd0);
        check_eq("rr_gnt2",    32'(b2.if_gnt),    32'd1);
        check_eq("rr_addr2",   b2.mem_addr,       32'h504);
        tick(); b2.if_req = 0; settle();
        check_eq("rr_rv_t1", 32'(b2.if_rvalid), 32'd0);
        tick(); settle();
        check_eq("rr_rv_t2",  32'(b2.if_rvalid), 32'd1);
        check_eq("rr_rdata",  b2.if_rdata,       32'h2222_0500);

        // Latency sweep on the MEM_LAT=3 instance with requests held off during WAIT.
        tick(); b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h600; settle();
        check_eq("ls_gnt", 32'(b3.d_gnt), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick(); b3.d_addr = 32'h604; b3.if_req = 1; b3.if_addr = 32'h700; settle();
            check_eq("ls_en",     32'(b3.mem_en),   32'd0);
            check_eq("ls_d_gnt",  32'(b3.d_gnt),    32'd0);
            check_eq("ls_if_gnt", 32'(b3.if_gnt),   32'd0);
            check_eq("ls_rvalid", 32'(b3.d_rvalid), 32'(i == 3));
        end
        check_eq("ls_rdata", b3.d_rdata, 32'h3333_0600);
        tick(); settle();
        check_eq("ls_regnt",  32'(b3.d_gnt), 32'd1);
        check_eq("ls_readdr", b3.mem_addr,   32'h604);
        tick(); b3.d_req = 0; b3.if_req = 0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end
endmodule
